// File: rtl/mux_pkg.sv
// Shared constants for the round-robin / static channel multiplexer.
package mux_pkg;
   localparam int N_CH_DEF  = 4;
   localparam int WIDTH_DEF = 8;

   // rr_mode encoding
   localparam logic MODE_STATIC = 1'b0;
   localparam logic MODE_RR     = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// Wrap-around priority search: first requester after ptr wins, ptr itself last.
module rr_pick #(
   parameter int N_CH = 4,
   localparam int CH_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [CH_W-1:0] ptr,
   output logic            gnt_vld,
   output logic [CH_W-1:0] gnt_idx
);

   logic [CH_W-1:0] w_idx;

   // Scan from farthest to nearest so the nearest hit is the one that sticks.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      w_idx   = '0;
      for (int k = N_CH; k >= 1; k--) begin
         w_idx = CH_W'((int'(ptr) + k) % N_CH);
         if (req[w_idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = w_idx;
         end
      end
   end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel registered mux with valid/ready handshakes, static or round-robin select.
module mux_rr_n
   import mux_pkg::*;
#(
   parameter int N_CH  = N_CH_DEF,
   parameter int WIDTH = WIDTH_DEF,
   localparam int CH_W = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   input  logic                  rr_mode,
   input  logic [CH_W-1:0]       sel,
   output logic [WIDTH-1:0]      out_data,
   output logic [CH_W-1:0]       out_ch,
   output logic                  out_valid,
   input  logic                  out_ready
);

   logic [N_CH-1:0][WIDTH-1:0] w_data;
   logic                       w_load;
   logic                       w_rr_vld;
   logic [CH_W-1:0]            w_rr_idx;
   logic                       w_st_vld;
   logic                       w_gnt_vld;
   logic [CH_W-1:0]            w_gnt_idx;
   logic                       w_xfer;
   logic [WIDTH-1:0]           w_sel_data;

   logic [WIDTH-1:0]           r_out_data;
   logic [CH_W-1:0]            r_out_ch;
   logic                       r_out_valid;
   logic [CH_W-1:0]            r_ptr;

   assign w_data = in_data;
   assign w_load = !r_out_valid || out_ready;

   rr_pick #(.N_CH(N_CH)) u_pick (
      .req     (in_valid),
      .ptr     (r_ptr),
      .gnt_vld (w_rr_vld),
      .gnt_idx (w_rr_idx)
   );

   // Static candidate: compare sel against each real channel so sel >= N_CH never hits.
   always_comb begin
      w_st_vld = 1'b0;
      for (int i = 0; i < N_CH; i++)
         if (sel == CH_W'(i) && in_valid[i]) w_st_vld = 1'b1;
   end

   // Mode mux picks the candidate channel for this cycle.
   always_comb begin
      w_gnt_vld = w_st_vld;
      w_gnt_idx = sel;
      case (rr_mode)
         MODE_RR: begin
            w_gnt_vld = w_rr_vld;
            w_gnt_idx = w_rr_idx;
         end
         MODE_STATIC: begin
            w_gnt_vld = w_st_vld;
            w_gnt_idx = sel;
         end
         default: ;
      endcase
   end

   // One-hot ready; forced low while reset is held so nothing appears to transfer.
   always_comb begin
      in_ready   = '0;
      w_sel_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (w_gnt_idx == CH_W'(i)) begin
            in_ready[i] = rst_n && w_load && w_gnt_vld;
            w_sel_data  = w_data[i];
         end
      end
   end

   assign w_xfer = rst_n && w_load && w_gnt_vld;

   // Output word, source channel and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_out_valid <= 1'b0;
         r_ptr       <= CH_W'(N_CH - 1);
      end else if (w_xfer) begin
         r_out_data  <= w_sel_data;
         r_out_ch    <= w_gnt_idx;
         r_out_valid <= 1'b1;
         r_ptr       <= w_gnt_idx;
      end else if (w_load) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n: a 4-channel and a 3-channel instance.
module tb_mux_rr_n;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 4-channel instance
   logic [31:0] d4_in_data;
   logic [3:0]  d4_in_valid, d4_in_ready;
   logic        d4_rr_mode, d4_out_valid, d4_out_ready;
   logic [1:0]  d4_sel, d4_out_ch;
   logic [7:0]  d4_out_data;

   // 3-channel instance
   logic [23:0] d3_in_data;
   logic [2:0]  d3_in_valid, d3_in_ready;
   logic        d3_rr_mode, d3_out_valid, d3_out_ready;
   logic [1:0]  d3_sel, d3_out_ch;
   logic [7:0]  d3_out_data;

   mux_rr_n #(.N_CH(4), .WIDTH(8)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_data(d4_in_data), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
      .rr_mode(d4_rr_mode), .sel(d4_sel),
      .out_data(d4_out_data), .out_ch(d4_out_ch), .out_valid(d4_out_valid),
      .out_ready(d4_out_ready)
   );

   mux_rr_n #(.N_CH(3), .WIDTH(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .in_data(d3_in_data), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
      .rr_mode(d3_rr_mode), .sel(d3_sel),
      .out_data(d3_out_data), .out_ch(d3_out_ch), .out_valid(d3_out_valid),
      .out_ready(d3_out_ready)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the 4-channel output register in one go.
   task automatic chk4(input string tag, input logic v, input logic [1:0] ch, input logic [7:0] d);
      chk({tag, ".vld"}, 32'(d4_out_valid), 32'(v));
      chk({tag, ".ch"},  32'(d4_out_ch),    32'(ch));
      chk({tag, ".dat"}, 32'(d4_out_data),  32'(d));
   endtask

   initial begin
      rst_n        = 1'b0;
      d4_in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      d4_in_valid  = 4'hF;
      d4_rr_mode   = 1'b1;
      d4_sel       = 2'd0;
      d4_out_ready = 1'b1;
      d3_in_data   = {8'hC2, 8'hC1, 8'hC0};
      d3_in_valid  = 3'b000;
      d3_rr_mode   = 1'b0;
      d3_sel       = 2'd0;
      d3_out_ready = 1'b1;

      // Reset held with every channel valid
      tick();
      tick();
      chk4("rst", 1'b0, 2'd0, 8'h00);
      chk("rst.rdy", 32'(d4_in_ready), 32'h0);

      // Release: channel 0 has first priority
      rst_n = 1'b1;
      #1;
      chk("rel.rdy", 32'(d4_in_ready), 32'b0001);

      // Round-robin, all valid: 0,1,2,3,0 with no bubbles
      tick(); chk4("rr0", 1'b1, 2'd0, 8'hA0);
      chk("rr0.rdy", 32'(d4_in_ready), 32'b0010);
      tick(); chk4("rr1", 1'b1, 2'd1, 8'hA1);
      tick(); chk4("rr2", 1'b1, 2'd2, 8'hA2);
      tick(); chk4("rr3", 1'b1, 2'd3, 8'hA3);
      tick(); chk4("rr4", 1'b1, 2'd0, 8'hA0);

      // Static sel=2, then stall
      d4_rr_mode  = 1'b0;
      d4_sel      = 2'd2;
      d4_in_valid = 4'b0100;
      d4_in_data  = {8'hA3, 8'h55, 8'hA1, 8'hA0};
      #1;
      chk("st.rdy", 32'(d4_in_ready), 32'b0100);
      tick(); chk4("st0", 1'b1, 2'd2, 8'h55);
      d4_out_ready = 1'b0;
      d4_in_data   = {8'hA3, 8'h66, 8'hA1, 8'hA0};
      #1;
      chk("stall.rdy", 32'(d4_in_ready), 32'h0);
      tick(); chk4("stall1", 1'b1, 2'd2, 8'h55);
      tick(); chk4("stall2", 1'b1, 2'd2, 8'h55);
      chk("stall2.rdy", 32'(d4_in_ready), 32'h0);
      d4_out_ready = 1'b1;
      #1;
      chk("unstall.rdy", 32'(d4_in_ready), 32'b0100);
      tick(); chk4("st1", 1'b1, 2'd2, 8'h66);

      // RR with only ch1/ch3: ptr=2, ch1 alone first to park ptr on 1
      d4_rr_mode  = 1'b1;
      d4_in_data  = {8'h33, 8'hA2, 8'h11, 8'hA0};
      d4_in_valid = 4'b0010;
      tick(); chk4("alt0", 1'b1, 2'd1, 8'h11);
      d4_in_valid = 4'b1010;
      #1;
      chk("alt.rdy", 32'(d4_in_ready), 32'b1000);
      tick(); chk4("alt1", 1'b1, 2'd3, 8'h33);
      tick(); chk4("alt2", 1'b1, 2'd1, 8'h11);
      d4_in_valid = 4'b0010;
      tick(); chk4("rep1", 1'b1, 2'd1, 8'h11);
      tick(); chk4("rep2", 1'b1, 2'd1, 8'h11);

      // Mode switch: RR serves ch0, static sel=3, back to RR resumes after ch3
      d4_in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      d4_in_valid = 4'b0001;
      tick(); chk4("ms0", 1'b1, 2'd0, 8'hA0);
      d4_in_valid = 4'hF;
      d4_rr_mode  = 1'b0;
      d4_sel      = 2'd3;
      #1;
      chk("ms.st.rdy", 32'(d4_in_ready), 32'b1000);
      tick(); chk4("ms1", 1'b1, 2'd3, 8'hA3);
      d4_rr_mode = 1'b1;
      #1;
      chk("ms.rr.rdy", 32'(d4_in_ready), 32'b0001);
      tick(); chk4("ms2", 1'b1, 2'd0, 8'hA0);

      // No candidate with load: valid drops, word held
      d4_in_valid = 4'b0000;
      #1;
      chk("idle.rdy", 32'(d4_in_ready), 32'h0);
      tick(); chk4("idle", 1'b0, 2'd0, 8'hA0);

      // 3-channel: hold a ch1 word, then sel=3 never grants
      d3_in_valid  = 3'b111;
      d3_sel       = 2'd1;
      d3_out_ready = 1'b0;
      tick();
      chk("n3.w.vld", 32'(d3_out_valid), 32'h1);
      chk("n3.w.ch",  32'(d3_out_ch),    32'h1);
      chk("n3.w.dat", 32'(d3_out_data),  32'hC1);
      d3_sel = 2'd3;
      #1;
      chk("n3.sel3.rdy", 32'(d3_in_ready), 32'h0);
      tick();
      chk("n3.hold.vld", 32'(d3_out_valid), 32'h1);
      d3_out_ready = 1'b1;
      #1;
      chk("n3.sel3.rdy2", 32'(d3_in_ready), 32'h0);
      tick();
      chk("n3.drain.vld", 32'(d3_out_valid), 32'h0);
      chk("n3.drain.dat", 32'(d3_out_data),  32'hC1);
      chk("n3.drain.ch",  32'(d3_out_ch),    32'h1);

      // Async reset mid-stream on both instances
      d3_sel      = 2'd0;
      d4_in_valid = 4'hF;
      tick();
      chk("n3.s0.dat", 32'(d3_out_data), 32'hC0);
      chk4("pre.rst", 1'b1, 2'd1, 8'hA1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.n3.vld", 32'(d3_out_valid), 32'h0);
      chk("arst.n3.dat", 32'(d3_out_data),  32'h0);
      chk("arst.n4.vld", 32'(d4_out_valid), 32'h0);
      chk("arst.n4.rdy", 32'(d4_in_ready),  32'h0);
      chk("arst.n3.rdy", 32'(d3_in_ready),  32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
